unity_decoder: RTL and testbench

Registered single-symbol-correcting Reed-Solomon decoder for the Unity ECC memory path. It accepts an 80-bit codeword of ten 8-bit GF(2^8) symbols: eight data symbols and two check symbols. It corrects any single erroneous symbol, flags detected-uncorrectable errors, and returns the 64-bit data word. It sits on the read-return path directly after the memory interface and before data is handed upstream.

---
 rtl/unity_ecc_pkg.sv | 24 ++
 rtl/gf256_const_mul.sv | 28 ++
 rtl/unity_decoder.sv | 79 +++++++
 tb/tb_unity_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/unity_ecc_pkg.sv
// Shared GF(2^8) constants and types for the Unity ECC decode path.
// Field is built on x^8+x^4+x^3+x^2+1 with alpha = 0x02.
package unity_ecc_pkg;

   localparam logic [8:0] GF_POLY      = 9'h11D;
   localparam int         SYM_W        = 8;
   localparam int         SYM_CNT      = 10;
   localparam int         DATA_SYM_CNT = 8;

   typedef logic [SYM_W-1:0]         symbol_t;
   typedef logic [SYM_W*SYM_CNT-1:0] codeword_t;

   localparam symbol_t ALPHA_POW [SYM_CNT] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A
   };

   // Multiply by alpha once: shift and fold the overflow bit back through the polynomial.
   function automatic symbol_t gf_xtime(input symbol_t a);
      symbol_t poly_lo;
      poly_lo = GF_POLY[7:0];
      return {a[6:0], 1'b0} ^ (a[7] ? poly_lo : 8'h00);
   endfunction

endpackage

// File: rtl/gf256_const_mul.sv
// Multiply a GF(2^8) symbol by the compile-time constant alpha^K.
// Column b of the XOR matrix is alpha^(K+b); all of it folds to constants.
module gf256_const_mul
   import unity_ecc_pkg::*;
#(
   parameter int unsigned K = 0
) (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   localparam symbol_t BASE = ALPHA_POW[K];

   symbol_t prod;
   symbol_t col;

   always_comb begin
      prod = '0;
      col  = BASE;
      for (int b = 0; b < SYM_W; b++) begin
         if (a_i[b]) prod = prod ^ col;
         col = gf_xtime(col);
      end
   end

   assign y_o = prod;

endmodule

// File: rtl/unity_decoder.sv
// Single-symbol-correcting RS decoder on the memory read-return path.
// Syndromes, locator and correction are combinational; outputs register once.
module unity_decoder
   import unity_ecc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [79:0] codeword_in,
   output logic        decode_result_out,
   output logic [63:0] data_out
);

   symbol_t             s1_term  [SYM_CNT];
   symbol_t             loc_term [SYM_CNT];
   symbol_t             s0;
   symbol_t             s1;
   logic [SYM_CNT-1:0]  match;
   logic                one_hit;
   logic [63:0]         corr_mask;
   logic [63:0]         data_d, data_q;
   logic                due_d, due_q;

   // Ten multipliers weight the S1 terms, ten more scale S0 for the locator compare.
   for (genvar i = 0; i < SYM_CNT; i++) begin : g_mul
      gf256_const_mul #(.K(i)) u_s1_mul (
         .a_i (codeword_in[SYM_W*i +: SYM_W]),
         .y_o (s1_term[i])
      );
      gf256_const_mul #(.K(i)) u_loc_mul (
         .a_i (s0),
         .y_o (loc_term[i])
      );
      assign match[i] = (loc_term[i] == s1);
   end

   always_comb begin
      s0 = '0;
      s1 = '0;
      for (int i = 0; i < SYM_CNT; i++) begin
         s0 = s0 ^ codeword_in[SYM_W*i +: SYM_W];
         s1 = s1 ^ s1_term[i];
      end
   end

   assign one_hit = (match != '0) && ((match & (match - 10'd1)) == '0);

   always_comb begin
      corr_mask = '0;
      for (int i = 0; i < DATA_SYM_CNT; i++) begin
         if (match[i]) corr_mask[SYM_W*i +: SYM_W] = s0;
      end
   end

   always_comb begin
      data_d = codeword_in[63:0];
      due_d  = 1'b0;
      if (s0 != '0 && s1 != '0) begin
         // A hit on a check symbol leaves corr_mask empty, so data passes through.
         if (one_hit) data_d = codeword_in[63:0] ^ corr_mask;
         else         due_d  = 1'b1;
      end else if (s0 != '0 || s1 != '0) begin
         due_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         due_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         due_q  <= due_d;
      end
   end

   assign data_out          = data_q;
   assign decode_result_out = due_q;

endmodule

// File: tb/tb_unity_decoder.sv
// Scoreboard bench for unity_decoder: expected results are queued as words are
// driven and compared one cycle later against a bit-serial GF reference.
module tb_unity_decoder;

   logic        clk;
   logic        rst_n;
   logic [79:0] codeword_in;
   logic        decode_result_out;
   logic [63:0] data_out;

   typedef struct packed {
      logic        due;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q [$];
   int   checks   = 0;
   int   failures = 0;

   unity_decoder dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .codeword_in       (codeword_in),
      .decode_result_out (decode_result_out),
      .data_out          (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      end
      return r;
   endfunction

   function automatic logic [7:0] alpha_pow(input int k);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < k; i++) r = gf_mul(r, 8'h02);
      return r;
   endfunction

   function automatic exp_t model(input logic [79:0] cw);
      exp_t       e;
      logic [7:0] s0, s1, c;
      int         hits, hj;
      s0 = 8'h00;
      s1 = 8'h00;
      for (int i = 0; i < 10; i++) begin
         c  = cw[8*i +: 8];
         s0 = s0 ^ c;
         s1 = s1 ^ gf_mul(c, alpha_pow(i));
      end
      e.data = cw[63:0];
      e.due  = 1'b0;
      if (s0 != 0 && s1 != 0) begin
         hits = 0;
         hj   = 0;
         for (int j = 0; j < 10; j++)
            if (gf_mul(s0, alpha_pow(j)) == s1) begin hits++; hj = j; end
         if (hits == 1) begin
            if (hj < 8) e.data[8*hj +: 8] = e.data[8*hj +: 8] ^ s0;
         end else e.due = 1'b1;
      end else if (s0 != 0 || s1 != 0) e.due = 1'b1;
      return e;
   endfunction

   // Build a valid codeword by brute-forcing the first check symbol.
   function automatic logic [79:0] encode(input logic [63:0] d);
      logic [7:0]  a, b, c8, c9;
      logic [79:0] cw;
      a = 8'h00;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         a = a ^ d[8*i +: 8];
         b = b ^ gf_mul(d[8*i +: 8], alpha_pow(i));
      end
      c8 = 8'h00;
      c9 = 8'h00;
      for (int v = 0; v < 256; v++) begin
         if ((gf_mul(8'(v), 8'h1D) ^ gf_mul(a ^ 8'(v), 8'h3A)) == b) begin
            c8 = 8'(v);
            c9 = a ^ 8'(v);
         end
      end
      cw = {c9, c8, d};
      return cw;
   endfunction

   task automatic pop_check();
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_val("data", data_out, e.data);
         check_val("due", {63'h0, decode_result_out}, {63'h0, e.due});
      end
   endtask

   task automatic step(input logic [79:0] cw);
      @(posedge clk);
      #1;
      pop_check();
      codeword_in = cw;
      exp_q.push_back(model(cw));
   endtask

   task automatic flush();
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      logic [79:0] cw;
      logic [63:0] d;
      logic [7:0]  ev;
      rst_n       = 1'b0;
      codeword_in = {$urandom(), $urandom(), 16'h5A5A};
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_data", data_out, 64'h0);
      check_val("rst_due", {63'h0, decode_result_out}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      step(80'h0);
      step({8'h00, 8'hA3, 64'h0});
      step({16'h0, 64'h55});
      step({16'h0, 64'h0101});
      flush();

      for (int i = 0; i < 8; i++) begin
         cw = '0;
         cw[8*i +: 8] = 8'($urandom_range(1, 255));
         step(cw);
      end
      for (int n = 0; n < 12; n++) begin
         d  = {$urandom(), $urandom()};
         cw = encode(d);
         ev = 8'($urandom_range(1, 255));
         cw[8*(n % 10) +: 8] = cw[8*(n % 10) +: 8] ^ ev;
         step(cw);
      end
      for (int n = 0; n < 6; n++) begin
         cw = encode({$urandom(), $urandom()});
         cw[8*(n % 5) +: 8]       = cw[8*(n % 5) +: 8] ^ 8'($urandom_range(1, 255));
         cw[8*((n % 5) + 5) +: 8] = cw[8*((n % 5) + 5) +: 8] ^ 8'($urandom_range(1, 255));
         step(cw);
      end

      // Back-to-back clean, correctable and DUE words.
      step(encode(64'h0123_4567_89AB_CDEF));
      cw = encode(64'hDEAD_BEEF_CAFE_F00D);
      cw[23:16] = cw[23:16] ^ 8'h7E;
      step(cw);
      step({16'h0, 64'h0101});
      flush();

      // Mid-stream reset must clear outputs before the next edge.
      step({16'h0, 64'h0101});
      @(posedge clk);
      #1;
      pop_check();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midrst_data", data_out, 64'h0);
      check_val("midrst_due", {63'h0, decode_result_out}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(encode(64'h1111_2222_3333_4444));
      flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
